hazard_ctrl: RTL and testbench

Parametrised forwarding and load-use interlock unit for the pipelined CPU. It tracks every in-flight register write in an internal destination-tag pipeline and selects, for each source operand of the instruction in ID, the youngest valid producer result or the register-file value. It raises a stall, and inserts bubbles into its own tag pipeline, while any operand depends on a load whose data is not yet available. It sits between the ID/EXE boundary and the datapath operand muxes, and owns hazard detection for any number of read ports and pipeline depths.

---
 rtl/hazard_ctrl.sv | 109 ++++++++++
 tb/tb_hazard_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Operand forwarding and load-use interlock driven by an
//               internal destination-tag pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int NPORTS     = 2,
    parameter int STAGES     = 3,
    parameter int LOAD_READY = 1,
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int CW         = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 id_valid_i,
    input  logic [NPORTS*AW-1:0] id_rr_i,
    input  logic [NPORTS-1:0]    id_use_i,
    input  logic [AW-1:0]        id_wr_i,
    input  logic                 id_we_i,
    input  logic                 id_load_i,
    input  logic                 flush_i,
    input  logic [STAGES*DW-1:0] stage_data_i,
    input  logic [NPORTS*DW-1:0] rf_data_i,
    output logic [NPORTS*DW-1:0] op_data_o,
    output logic [NPORTS-1:0]    fwd_hit_o,
    output logic                 stall_o,
    output logic [CW-1:0]        stall_cnt_o
);

    // Destination-tag pipeline, index 0 is EXE.
    logic [STAGES-1:0]         r_valid;
    logic [STAGES-1:0][AW-1:0] r_wr;
    logic [STAGES-1:0]         r_we;
    logic [STAGES-1:0]         r_load;
    logic [CW-1:0]             r_stall_cnt;

    logic [NPORTS-1:0]         w_blocked;
    logic                      w_stall;
    logic                      w_issue;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic [AW-1:0] w_rr;
        logic [DW-1:0] w_op;
        logic          w_hit;
        logic          w_blk;
        logic          w_found;

        assign w_rr = id_rr_i[p*AW +: AW];

        // Only the youngest matching producer is considered; an older,
        // ready producer must not mask a younger load still in flight.
        always_comb begin
            w_found = 1'b0;
            w_hit   = 1'b0;
            w_blk   = 1'b0;
            w_op    = rf_data_i[p*DW +: DW];
            for (int s = 0; s < STAGES; s++) begin
                if (!w_found && id_use_i[p] && r_valid[s] && r_we[s] &&
                    (r_wr[s] == w_rr) && (w_rr != '0)) begin
                    w_found = 1'b1;
                    if (r_load[s] && (s < LOAD_READY)) begin
                        w_blk = 1'b1;
                    end else begin
                        w_hit = 1'b1;
                        w_op  = stage_data_i[s*DW +: DW];
                    end
                end
            end
        end

        assign op_data_o[p*DW +: DW] = w_op;
        assign fwd_hit_o[p]          = w_hit;
        assign w_blocked[p]          = w_blk;
    end

    assign w_stall     = id_valid_i & ~flush_i & (|w_blocked);
    assign w_issue     = id_valid_i & ~flush_i & ~w_stall;
    assign stall_o     = w_stall;
    assign stall_cnt_o = r_stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid     <= '0;
            r_wr        <= '0;
            r_we        <= '0;
            r_load      <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_valid[0] <= w_issue;
            r_wr[0]    <= id_wr_i;
            r_we[0]    <= id_we_i;
            r_load[0]  <= id_load_i;
            for (int s = 1; s < STAGES; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_wr[s]    <= r_wr[s-1];
                r_we[s]    <= r_we[s-1];
                r_load[s]  <= r_load[s-1];
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed bench for hazard_ctrl (LOAD_READY=1 and 2 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int c_DW = 32;
    localparam int c_AW = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            id_valid;
    logic [9:0]      id_rr;
    logic [1:0]      id_use;
    logic [4:0]      id_wr;
    logic            id_we;
    logic            id_load;
    logic            flush;
    logic [95:0]     stage_data;
    logic [63:0]     rf_data;

    logic [63:0]     op_data,  op_data2;
    logic [1:0]      fwd_hit,  fwd_hit2;
    logic            stall,    stall2;
    logic [31:0]     stall_cnt, stall_cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rr_i(id_rr),
        .id_use_i(id_use), .id_wr_i(id_wr), .id_we_i(id_we), .id_load_i(id_load),
        .flush_i(flush), .stage_data_i(stage_data), .rf_data_i(rf_data),
        .op_data_o(op_data), .fwd_hit_o(fwd_hit), .stall_o(stall),
        .stall_cnt_o(stall_cnt)
    );

    hazard_ctrl #(.LOAD_READY(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rr_i(id_rr),
        .id_use_i(id_use), .id_wr_i(id_wr), .id_we_i(id_we), .id_load_i(id_load),
        .flush_i(flush), .stage_data_i(stage_data), .rf_data_i(rf_data),
        .op_data_o(op_data2), .fwd_hit_o(fwd_hit2), .stall_o(stall2),
        .stall_cnt_o(stall_cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                          input logic [1:0] u, input logic [4:0] wr,
                          input logic we, input logic ld);
        id_valid = v;
        id_rr    = {r1, r0};
        id_use   = u;
        id_wr    = wr;
        id_we    = we;
        id_load  = ld;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        repeat (4) tick();
    endtask

    initial begin
        set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        flush      = 1'b0;
        rf_data    = {32'h0000_F1F1, 32'h0000_F0F0};
        stage_data = {32'h0000_CCCC, 32'h0000_AAAA, 32'h0000_1234};

        // Reset state
        @(negedge clk);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_hit",   {62'd0, fwd_hit}, 64'd0);
        chk("rst_op",    op_data, 64'h0000_F1F1_0000_F0F0);
        chk("rst_cnt",   {32'd0, stall_cnt}, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // ALU forwarding: add x5 then read x5 on port 0
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("alu_hit",   {62'd0, fwd_hit}, 64'd1);
        chk("alu_op0",   {32'd0, op_data[31:0]}, 64'h1234);
        chk("alu_op1",   {32'd0, op_data[63:32]}, 64'hF1F1);
        chk("alu_stall", {63'd0, stall}, 64'd0);
        tick();

        // Load-use: lw x6 then read x6 on port 1
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd6, 2'b10, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("lu_stall_a",  {63'd0, stall}, 64'd1);
        chk("lu_hit_a",    {62'd0, fwd_hit}, 64'd0);
        chk("lu_op1_a",    {32'd0, op_data[63:32]}, 64'hF1F1);
        chk("lu2_stall_a", {63'd0, stall2}, 64'd1);
        tick();
        @(negedge clk);
        chk("lu_stall_b",  {63'd0, stall}, 64'd0);
        chk("lu_hit_b",    {62'd0, fwd_hit}, 64'd2);
        chk("lu_op1_b",    {32'd0, op_data[63:32]}, 64'hAAAA);
        chk("lu_cnt_b",    {32'd0, stall_cnt}, 64'd1);
        chk("lu2_stall_b", {63'd0, stall2}, 64'd1);
        chk("lu2_cnt_b",   {32'd0, stall_cnt2}, 64'd1);
        tick();
        @(negedge clk);
        chk("lu2_stall_c", {63'd0, stall2}, 64'd0);
        chk("lu2_hit_c",   {62'd0, fwd_hit2}, 64'd2);
        chk("lu2_op1_c",   {32'd0, op_data2[63:32]}, 64'hCCCC);
        chk("lu2_cnt_c",   {32'd0, stall_cnt2}, 64'd2);
        chk("lu_cnt_c",    {32'd0, stall_cnt}, 64'd1);
        drain();

        // x0 is never forwarded
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("x0_hit",   {62'd0, fwd_hit}, 64'd0);
        chk("x0_op",    op_data, 64'h0000_F1F1_0000_F0F0);
        chk("x0_stall", {63'd0, stall}, 64'd0);
        drain();

        // Youngest producer wins: x7 in stage 1 and stage 0
        stage_data = {32'h0000_CCCC, 32'h0000_AAAA, 32'h0000_BBBB};
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd7, 5'd7, 2'b11, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("young_hit", {62'd0, fwd_hit}, 64'd3);
        chk("young_op",  op_data, 64'h0000_BBBB_0000_BBBB);
        drain();

        // Flush during a load-use stall
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd9, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0);
        @(negedge clk);
        chk("fl_stall_pre", {63'd0, stall}, 64'd1);
        flush = 1'b1;
        #1;
        chk("fl_stall", {63'd0, stall}, 64'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("fl_op_s1",  {32'd0, op_data[31:0]}, 64'hAAAA);
        chk("fl_hit_s1", {62'd0, fwd_hit}, 64'd1);
        chk("fl_cnt",    {32'd0, stall_cnt}, 64'd1);
        set_id(1'b0, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("fl_op_s2", {32'd0, op_data[31:0]}, 64'hCCCC);
        set_id(1'b0, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("fl_retired", {62'd0, fwd_hit}, 64'd0);
        drain();

        // Asynchronous reset in the middle of a stall
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd6, 2'b10, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("ar_stall_pre", {63'd0, stall}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_stall", {63'd0, stall}, 64'd0);
        chk("ar_hit",   {62'd0, fwd_hit}, 64'd0);
        chk("ar_cnt",   {32'd0, stall_cnt}, 64'd0);
        chk("ar_op",    op_data, 64'h0000_F1F1_0000_F0F0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("ar_post_stall", {63'd0, stall}, 64'd0);
        chk("ar_post_hit",   {62'd0, fwd_hit}, 64'd0);
        tick();
        @(negedge clk);
        chk("ar_post_stall2", {63'd0, stall}, 64'd0);
        chk("ar_post_cnt",    {32'd0, stall_cnt}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
